// File: rtl/mult_pkg.sv
// Shared defaults and state encoding for the multiplier datapath.
// Used by the product accumulator and the multiplier.
package mult_pkg;

  localparam int PROD_W = 4;
  localparam int ACC_W  = 12;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } acc_st_t;

endpackage

// File: rtl/acc_add.sv
// Accumulator adder: sum + product with carry-out.
// ACC_SAT_EN defined: clamp to all-ones on carry, else wrap.
module acc_add #(
  parameter int PROD_W = mult_pkg::PROD_W,
  parameter int ACC_W  = mult_pkg::ACC_W
) (
  input  logic [ACC_W-1:0]  sum,
  input  logic [PROD_W-1:0] prod,
  output logic [ACC_W-1:0]  sum_nxt,
  output logic              carry
);

  logic [ACC_W:0] wide;

  assign wide  = {1'b0, sum} + (ACC_W+1)'(prod);
  assign carry = wide[ACC_W];

`ifdef ACC_SAT_EN
  assign sum_nxt = carry ? '1 : wide[ACC_W-1:0];
`else
  assign sum_nxt = wide[ACC_W-1:0];
`endif

endmodule

// File: rtl/prod_accum.sv
// Sums LEN products per frame and offers the result on a handshake.
// Overflow policy selected by ACC_SAT_EN (see acc_add).
module prod_accum #(
  parameter int PROD_W = mult_pkg::PROD_W,
  parameter int ACC_W  = mult_pkg::ACC_W,
  parameter int LEN    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              acc_clr,
  input  logic              prod_valid,
  output logic              prod_ready,
  input  logic [PROD_W-1:0] prod_data,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic [ACC_W-1:0]  acc_data,
  output logic              acc_ovf
);

  import mult_pkg::*;

  localparam int CNT_W = $clog2(LEN + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

  acc_st_t          state;
  logic [ACC_W-1:0] sum;
  logic [ACC_W-1:0] sum_nxt;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             ovf;

  acc_add #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_add (
    .sum     (sum),
    .prod    (prod_data),
    .sum_nxt (sum_nxt),
    .carry   (carry)
  );

  assign prod_ready = (state == ST_ACCUM) && !acc_clr;
  assign acc_valid  = (state == ST_HOLD);
  assign acc_data   = sum;
  assign acc_ovf    = ovf;

  // Frame FSM: accumulate LEN beats, then hold the result until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_ACCUM;
      sum   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      unique case (1'b1)
        (state == ST_ACCUM): begin
          if (acc_clr) begin
            sum <= '0;
            cnt <= '0;
            ovf <= 1'b0;
          end else if (prod_valid) begin
            sum <= sum_nxt;
            ovf <= ovf | carry;
            if (cnt == LAST) begin
              cnt   <= '0;
              state <= ST_HOLD;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        (state == ST_HOLD): begin
          if (acc_clr || acc_ready) begin
            sum   <= '0;
            ovf   <= 1'b0;
            state <= ST_ACCUM;
          end
        end
        default: state <= ST_ACCUM;
      endcase
    end
  end

endmodule
